output_holder: RTL and testbench

- Downstream neighbour of the stream-cipher interface FSM.
- Collects processed bytes from the cipher core through a valid/ready handshake and packs them into one output word.
- Raises output_is_ready to the interface FSM when the word is complete.
- Presents the word on the chip output pins while the interface is in I_DONE, then clears for the next transaction.

---
 rtl/types_pkg.sv | 33 +++
 rtl/output_byte_packer.sv | 90 +++++++++
 rtl/output_holder.sv | 107 ++++++++++
 tb/tb_output_holder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// ============================================================================
// Module : types_pkg
// Brief  : Shared state encodings and limits for the cipher interface/holder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package types_pkg;

    typedef enum logic [1:0] {
        I_IDLE       = 2'd0,
        I_LOAD       = 2'd1,
        I_PROCESSING = 2'd2,
        I_DONE       = 2'd3
    } interface_state_t;

    // H_IDLE must stay at zero so a cleared state register means idle.
    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_FILL    = 2'd1,
        H_FULL    = 2'd2,
        H_PRESENT = 2'd3
    } holder_state_t;

    localparam int HOLDER_MAX_BYTES = 16;

    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_byte_packer.sv
// ============================================================================
// Module : output_byte_packer
// Brief  : Lane register, byte counter and last-byte flag for output_holder.
//          Optional OUTPUT_HOLDER_PARITY_EN adds a per-lane parity register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_byte_packer
    import types_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_BYTES  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic                            clear,
    input  logic [DATA_WIDTH-1:0]           byte_in,
    output logic [OUT_BYTES*DATA_WIDTH-1:0] word,
    output logic                            last
`ifdef OUTPUT_HOLDER_PARITY_EN
    ,
    output logic [OUT_BYTES-1:0]            parity
`endif
);

    localparam int                CNT_W    = count_width(OUT_BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(OUT_BYTES - 1);

    logic [CNT_W-1:0]                count_q, count_d;
    logic [OUT_BYTES*DATA_WIDTH-1:0] word_q, word_d;

    always_comb begin
        count_d = count_q;
        word_d  = word_q;
        if (clear) begin
            count_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < OUT_BYTES; i++) begin
                if (count_q == CNT_W'(i)) begin
                    word_d[i*DATA_WIDTH +: DATA_WIDTH] = byte_in;
                end
            end
            // Wrap to zero on the last lane so the next word starts at lane 0.
            count_d = (count_q == LAST_IDX) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            word_q  <= '0;
        end else begin
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    assign word = word_q;
    assign last = (count_q == LAST_IDX);

`ifdef OUTPUT_HOLDER_PARITY_EN
    logic [OUT_BYTES-1:0] parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (!clear && wr_en) begin
            for (int i = 0; i < OUT_BYTES; i++) begin
                if (count_q == CNT_W'(i)) begin
                    parity_d[i] = ^byte_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: rtl/output_holder.sv
// ============================================================================
// Module : output_holder
// Brief  : Packs cipher bytes into an output word and presents it on I_DONE.
//          Optional OUTPUT_HOLDER_PARITY_EN adds the data_parity output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_holder
    import types_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_BYTES  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  interface_state_t                interface_state,
    input  logic [DATA_WIDTH-1:0]           cipher_data,
    input  logic                            cipher_valid,
    output logic                            cipher_ready,
    output logic                            output_is_ready,
    output logic [OUT_BYTES*DATA_WIDTH-1:0] data_out,
    output logic                            data_out_valid,
    output holder_state_t                   holder_state_out
`ifdef OUTPUT_HOLDER_PARITY_EN
    ,
    output logic [OUT_BYTES-1:0]            data_parity
`endif
);

    holder_state_t state_q, state_d;
    logic          wr_en;
    logic          clear;
    logic          last;

    output_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_BYTES  (OUT_BYTES)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .clear   (clear),
        .byte_in (cipher_data),
        .word    (data_out),
        .last    (last)
`ifdef OUTPUT_HOLDER_PARITY_EN
        ,
        .parity  (data_parity)
`endif
    );

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            H_IDLE: begin
                if (interface_state == I_PROCESSING) begin
                    state_d = H_FILL;
                    clear   = 1'b1;
                end
            end
            H_FILL: begin
                // Abort takes priority over a byte offered in the same cycle.
                if (interface_state == I_IDLE) begin
                    state_d = H_IDLE;
                    clear   = 1'b1;
                end else if (cipher_valid) begin
                    wr_en = 1'b1;
                    if (last) begin
                        state_d = H_FULL;
                    end
                end
            end
            H_FULL: begin
                if (interface_state == I_DONE) begin
                    state_d = H_PRESENT;
                end else if (interface_state == I_IDLE) begin
                    state_d = H_IDLE;
                end
            end
            H_PRESENT: begin
                if (interface_state == I_IDLE) begin
                    state_d = H_IDLE;
                end
            end
            default: state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= H_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cipher_ready     = (state_q == H_FILL);
    assign output_is_ready  = (state_q == H_FULL) || (state_q == H_PRESENT);
    assign data_out_valid   = (state_q == H_PRESENT);
    assign holder_state_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_output_holder.sv
// ============================================================================
// Module : tb_output_holder
// Brief  : Randomised scoreboard bench for output_holder (OUT_BYTES=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_holder;
    import types_pkg::*;

    localparam int DW = 8;
    localparam int NB = 4;

    logic                clk = 1'b0;
    logic                rst;
    interface_state_t    interface_state;
    logic [DW-1:0]       cipher_data;
    logic                cipher_valid;
    logic                cipher_ready;
    logic                output_is_ready;
    logic [NB*DW-1:0]    data_out;
    logic                data_out_valid;
    holder_state_t       holder_state_out;
`ifdef OUTPUT_HOLDER_PARITY_EN
    logic [NB-1:0]       data_parity;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle 1=fill 2=full 3=present
    int               mdl_phase;
    int               mdl_cnt;
    logic [DW-1:0]    mdl_lanes [NB];
    logic [NB*DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    output_holder #(.DATA_WIDTH(DW), .OUT_BYTES(NB)) dut (
        .clk              (clk),
        .rst              (rst),
        .interface_state  (interface_state),
        .cipher_data      (cipher_data),
        .cipher_valid     (cipher_valid),
        .cipher_ready     (cipher_ready),
        .output_is_ready  (output_is_ready),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .holder_state_out (holder_state_out)
`ifdef OUTPUT_HOLDER_PARITY_EN
        ,
        .data_parity      (data_parity)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB*DW-1:0] mdl_word();
        logic [NB*DW-1:0] w;
        for (int i = 0; i < NB; i++) w[i*DW +: DW] = mdl_lanes[i];
        return w;
    endfunction

    function automatic logic [NB-1:0] mdl_parity();
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^mdl_lanes[i];
        return p;
    endfunction

    task automatic mdl_update(input logic r, input interface_state_t ist,
                              input logic v, input logic [DW-1:0] d);
        if (r) begin
            mdl_phase = 0;
            mdl_cnt   = 0;
            for (int i = 0; i < NB; i++) mdl_lanes[i] = '0;
        end else begin
            case (mdl_phase)
                0: if (ist == I_PROCESSING) begin mdl_phase = 1; mdl_cnt = 0; end
                1: begin
                    if (ist == I_IDLE) begin
                        mdl_phase = 0; mdl_cnt = 0;
                    end else if (v) begin
                        mdl_lanes[mdl_cnt] = d;
                        mdl_cnt++;
                        if (mdl_cnt == NB) begin mdl_phase = 2; mdl_cnt = 0; end
                    end
                end
                2: begin
                    if (ist == I_DONE) begin
                        mdl_phase = 3;
                        exp_q.push_back(mdl_word());
                    end else if (ist == I_IDLE) begin
                        mdl_phase = 0;
                    end
                end
                default: if (ist == I_IDLE) mdl_phase = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("state", 64'(holder_state_out), 64'(mdl_phase));
        chk("cipher_ready", 64'(cipher_ready), 64'(mdl_phase == 1));
        chk("output_is_ready", 64'(output_is_ready), 64'(mdl_phase >= 2));
        chk("data_out_valid", 64'(data_out_valid), 64'(mdl_phase == 3));
        chk("data_out", 64'(data_out), 64'(mdl_word()));
`ifdef OUTPUT_HOLDER_PARITY_EN
        chk("data_parity", 64'(data_parity), 64'(mdl_parity()));
`endif
    endtask

    task automatic step(input logic r, input interface_state_t ist,
                        input logic v, input logic [DW-1:0] d);
        rst = r; interface_state = ist; cipher_valid = v; cipher_data = d;
        @(posedge clk);
        mdl_update(r, ist, v, d);
        #1;
        check_outputs();
    endtask

    // Scoreboard monitor: each new presentation must match the oldest expected word.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (data_out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got word %0h expected no presentation", data_out);
                end else begin
                    chk("sb_word", 64'(data_out), 64'(exp_q.pop_front()));
                end
            end
            prev_valid = data_out_valid;
        end
    end

    initial begin
        logic [DW-1:0] bytes [4];
        logic [DW-1:0] pbytes [4];
        int unsigned   r;
        interface_state_t ist;
        bytes  = '{8'h11, 8'h22, 8'h33, 8'h44};
        pbytes = '{8'h01, 8'h03, 8'h07, 8'hFF};
        mdl_phase = 0; mdl_cnt = 0;
        for (int i = 0; i < NB; i++) mdl_lanes[i] = '0;
        rst = 1'b1; interface_state = I_IDLE; cipher_valid = 1'b0; cipher_data = '0;

        step(1'b1, I_IDLE, 1'b0, 8'h00);
        step(1'b1, I_IDLE, 1'b0, 8'h00);

        // Reset mid-fill
        step(1'b0, I_PROCESSING, 1'b0, 8'h00);
        step(1'b0, I_PROCESSING, 1'b1, 8'hA1);
        step(1'b0, I_PROCESSING, 1'b1, 8'hA2);
        step(1'b1, I_PROCESSING, 1'b1, 8'hA3);
        chk("t1_data_out", 64'(data_out), 64'h0);
        chk("t1_state", 64'(holder_state_out), 64'(H_IDLE));

        // Back-to-back fill, then full handshake
        step(1'b0, I_PROCESSING, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, I_PROCESSING, 1'b1, bytes[i]);
        chk("t2_word", 64'(data_out), 64'h44332211);
        chk("t2_oready", 64'(output_is_ready), 64'h1);
        step(1'b0, I_PROCESSING, 1'b1, 8'h55);
        step(1'b0, I_LOAD, 1'b1, 8'h66);
        chk("t2_ready_full", 64'(cipher_ready), 64'h0);
        for (int i = 0; i < 3; i++) step(1'b0, I_DONE, 1'b0, 8'h00);
        chk("t4_dvalid", 64'(data_out_valid), 64'h1);
        step(1'b0, I_IDLE, 1'b0, 8'h00);
        chk("t4_dvalid_off", 64'(data_out_valid), 64'h0);
        chk("t4_hold", 64'(data_out), 64'h44332211);
        step(1'b0, I_IDLE, 1'b0, 8'h00);

        // Bubbles
        step(1'b0, I_PROCESSING, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, I_PROCESSING, 1'b1, bytes[3-i]);
            if (i < 3) step(1'b0, I_PROCESSING, 1'b0, 8'hEE);
        end
        chk("t3_word", 64'(data_out), 64'h11223344);
        step(1'b0, I_DONE, 1'b0, 8'h00);
        step(1'b0, I_IDLE, 1'b0, 8'h00);

        // Abort colliding with the final byte
        step(1'b0, I_PROCESSING, 1'b0, 8'h00);
        step(1'b0, I_PROCESSING, 1'b1, 8'h61);
        step(1'b0, I_PROCESSING, 1'b1, 8'h62);
        step(1'b0, I_PROCESSING, 1'b1, 8'h63);
        step(1'b0, I_IDLE, 1'b1, 8'h64);
        chk("t5_word", 64'(data_out), 64'h11636261);
        chk("t5_oready", 64'(output_is_ready), 64'h0);
        step(1'b0, I_IDLE, 1'b0, 8'h00);

        // Parity pattern
        step(1'b0, I_PROCESSING, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, I_PROCESSING, 1'b1, pbytes[i]);
`ifdef OUTPUT_HOLDER_PARITY_EN
        chk("t6_parity", 64'(data_parity), 64'b0101);
`endif
        step(1'b0, I_DONE, 1'b0, 8'h00);
        step(1'b0, I_IDLE, 1'b0, 8'h00);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      ist = I_IDLE;
            else if (r == 1) ist = I_LOAD;
            else if (r < 7)  ist = I_PROCESSING;
            else             ist = I_DONE;
            step(($urandom_range(0, 49) == 0), ist,
                 ($urandom_range(0, 9) < 7), DW'($urandom));
        end

        step(1'b0, I_IDLE, 1'b0, 8'h00);
        step(1'b0, I_IDLE, 1'b0, 8'h00);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
